// File: rtl/gelato_warp_issue_arbiter.sv
// Round-robin issue arbiter: picks one eligible warp per cycle, pops its instruction buffer and
// registers the instruction into a single-entry valid/ready output stage.
module gelato_warp_issue_arbiter #(
  parameter int unsigned NUM_WARPS = 8,
  parameter int unsigned INST_W    = 64,
  parameter int unsigned WID_W     = $clog2(NUM_WARPS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rdy,
  input  logic [NUM_WARPS-1:0]        ibuf_valid,
  input  logic [NUM_WARPS*INST_W-1:0] ibuf_inst,
  input  logic [NUM_WARPS-1:0]        warp_stall,
  output logic [NUM_WARPS-1:0]        ibuf_pop,
  output logic                        issue_valid,
  input  logic                        issue_ready,
  output logic [WID_W-1:0]            issue_warp_id,
  output logic [INST_W-1:0]           issue_inst,
  output logic [31:0]                 issue_count
);

  logic [NUM_WARPS-1:0] elig;
  logic [WID_W-1:0]     rr_ptr_q;
  logic [WID_W-1:0]     grant;
  logic [WID_W-1:0]     idx;
  logic                 found;
  logic                 load;
  logic                 accept;

  assign elig = ibuf_valid & ~warp_stall;

  // First eligible warp at or after rr_ptr; index arithmetic wraps since NUM_WARPS is 2^WID_W.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_WARPS; i++) begin
      idx = rr_ptr_q + WID_W'(i);
      if (!found && elig[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  assign accept = rdy & issue_valid & issue_ready;
  // rst_n is an active-high reset despite its name; nothing is popped while it is asserted.
  assign load   = ~rst_n & rdy & (~issue_valid | issue_ready) & found;

  always_comb begin
    ibuf_pop = '0;
    if (load) ibuf_pop[grant] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      issue_valid   <= 1'b0;
      issue_warp_id <= '0;
      issue_inst    <= '0;
      issue_count   <= '0;
      rr_ptr_q      <= '0;
    end else begin
      if (accept) issue_count <= issue_count + 32'd1;
      if (load) begin
        issue_inst    <= ibuf_inst[grant*INST_W +: INST_W];
        issue_warp_id <= grant;
        issue_valid   <= 1'b1;
        rr_ptr_q      <= grant + WID_W'(1);
      end else if (accept) begin
        issue_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gelato_warp_issue_arbiter.sv
// Randomized and directed bench for the warp issue arbiter, checked every cycle against a
// behavioural model of the round-robin selection and the single-entry output stage.
module tb_gelato_warp_issue_arbiter;

  localparam int N  = 4;
  localparam int IW = 64;
  localparam int WW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            rdy = 1'b0;
  logic [N-1:0]    ibuf_valid = '0;
  logic [N*IW-1:0] ibuf_inst = '0;
  logic [N-1:0]    warp_stall = '0;
  logic [N-1:0]    ibuf_pop;
  logic            issue_valid;
  logic            issue_ready = 1'b0;
  logic [WW-1:0]   issue_warp_id;
  logic [IW-1:0]   issue_inst;
  logic [31:0]     issue_count;

  gelato_warp_issue_arbiter #(.NUM_WARPS(N), .INST_W(IW)) dut (
    .clk          (clk),
    .rst_n        (rst),
    .rdy          (rdy),
    .ibuf_valid   (ibuf_valid),
    .ibuf_inst    (ibuf_inst),
    .warp_stall   (warp_stall),
    .ibuf_pop     (ibuf_pop),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_warp_id(issue_warp_id),
    .issue_inst   (issue_inst),
    .issue_count  (issue_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state
  int          m_ptr   = 0;
  logic        m_valid = 1'b0;
  int          m_wid   = 0;
  logic [63:0] m_inst  = '0;
  logic [31:0] m_count = '0;

  // Warp chosen this cycle, or -1 if nothing is popped.
  function automatic int pick();
    if (rst || !rdy || (m_valid && !issue_ready)) return -1;
    for (int i = 0; i < N; i++) begin
      int w;
      w = (m_ptr + i) % N;
      if (ibuf_valid[w] && !warp_stall[w]) return w;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_pop();
    int w;
    logic [N-1:0] p;
    w = pick();
    p = '0;
    if (w >= 0) p[w] = 1'b1;
    return p;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ptr <= 0; m_valid <= 1'b0; m_wid <= 0; m_inst <= '0; m_count <= '0;
    end else if (rdy) begin
      int w;
      w = pick();
      if (m_valid && issue_ready) m_count <= m_count + 32'd1;
      if (w >= 0) begin
        m_inst  <= ibuf_inst[w*IW +: IW];
        m_wid   <= w;
        m_valid <= 1'b1;
        m_ptr   <= (w + 1) % N;
      end else if (m_valid && issue_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("pop", 64'(ibuf_pop), 64'(exp_pop()));
    chk("valid", 64'(issue_valid), 64'(m_valid));
    chk("count", 64'(issue_count), 64'(m_count));
    chk("warp_id", 64'(issue_warp_id), 64'(m_wid));
    chk("inst", issue_inst, m_inst);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_insts(input logic [63:0] base);
    for (int w = 0; w < N; w++) ibuf_inst[w*IW +: IW] = base + 64'(w);
  endtask

  logic [31:0] c0;

  initial begin
    // Reset: pop must stay low even with valid, eligible buffers.
    ibuf_valid = 4'hF; rdy = 1'b1; issue_ready = 1'b1; set_insts(64'h1000);
    @(negedge clk);
    chk("rst_pop", 64'(ibuf_pop), 64'h0);
    chk("rst_valid", 64'(issue_valid), 64'h0);
    chk("rst_count", 64'(issue_count), 64'h0);
    step();
    rst = 1'b0;

    // All valid, no stall: w0,w1,w2,w3,w0.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rr_pop", 64'(ibuf_pop), 64'(1 << (k % 4)));
      step();
    end
    chk("rr_count", 64'(issue_count), 64'd4);
    chk("rr_valid", 64'(issue_valid), 64'd1);

    // Only warp 2 valid, then back-pressure holds it.
    ibuf_valid = 4'b0100; ibuf_inst[2*IW +: IW] = 64'hDEAD_BEEF;
    @(negedge clk);
    chk("w2_pop", 64'(ibuf_pop), 64'h4);
    step();
    issue_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_pop", 64'(ibuf_pop), 64'h0);
      chk("hold_inst", issue_inst, 64'hDEAD_BEEF);
      chk("hold_wid", 64'(issue_warp_id), 64'd2);
      step();
    end
    issue_ready = 1'b1;
    @(negedge clk);
    chk("w2_repop", 64'(ibuf_pop), 64'h4);
    step();

    // Ready toggling 1,0,1,0 with all warps valid: two accepts.
    ibuf_valid = 4'hF; set_insts(64'h2000);
    c0 = m_count;
    for (int k = 0; k < 4; k++) begin
      issue_ready = (k % 2 == 0);
      step();
    end
    chk("bp_count", 64'(issue_count), 64'(c0 + 32'd2));

    // rdy low freezes everything.
    issue_ready = 1'b1; rdy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("frz_pop", 64'(ibuf_pop), 64'h0);
      step();
    end
    rdy = 1'b1;

    // Asynchronous reset between edges.
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(issue_valid), 64'h0);
    chk("arst_count", 64'(issue_count), 64'h0);
    chk("arst_pop", 64'(ibuf_pop), 64'h0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_pop", 64'(ibuf_pop), 64'h1);
    step();

    // Stall warps 0 and 2: w1,w3,w1.
    warp_stall = 4'b0101;
    @(negedge clk); chk("stall_pop0", 64'(ibuf_pop), 64'h2); step();
    @(negedge clk); chk("stall_pop1", 64'(ibuf_pop), 64'h8); step();
    @(negedge clk); chk("stall_pop2", 64'(ibuf_pop), 64'h2); step();

    // Random traffic, with occasional resets and rdy drops.
    for (int k = 0; k < 3000; k++) begin
      ibuf_valid  = 4'($urandom);
      warp_stall  = 4'($urandom_range(0, 3) == 0 ? $urandom : 0);
      issue_ready = ($urandom_range(0, 3) != 0);
      rdy         = ($urandom_range(0, 9) != 0);
      rst         = ($urandom_range(0, 299) == 0);
      for (int w = 0; w < N; w++) ibuf_inst[w*IW +: IW] = {$urandom, $urandom};
      step();
    end
    rst = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gelato_warp_issue_arbiter.md
Name: gelato_warp_issue_arbiter

Overview:
Sits directly downstream of the per-warp instruction buffers. Each cycle it selects one warp whose buffered decoded instruction is eligible and pops it from that warp's buffer. Selection is round-robin over NUM_WARPS warps. The selected instruction is registered into a single-entry output stage, which hands it to the operand-collect/dispatch stage through a valid/ready handshake.

Parameters:
NUM_WARPS, 8, number of warps (and instruction buffers) arbitrated; power of two, 2..32
INST_W, 64, width of one decoded instruction word
WID_W, $clog2(NUM_WARPS), width of the warp id

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-high reset (asserted when 1)
rdy  input  1  global enable; 0 freezes all state
ibuf_valid  input  NUM_WARPS  bit w = warp w buffer holds an instruction at its head
ibuf_inst  input  NUM_WARPS*INST_W  head instruction of warp w at bits [w*INST_W +: INST_W]
warp_stall  input  NUM_WARPS  bit w = warp w blocked (scoreboard hazard/barrier); not eligible
ibuf_pop  output  NUM_WARPS  one-hot or zero; bit w pops warp w buffer head this cycle
issue_valid  output  1  output stage holds an instruction
issue_ready  input  1  downstream accepts this cycle
issue_warp_id  output  WID_W  warp of held instruction
issue_inst  output  INST_W  held instruction
issue_count  output  32  total instructions handed downstream, wraps at 2^32

Behaviour:
- Reset (rst_n=1, async): issue_valid=0, issue_warp_id=0, issue_inst=0, issue_count=0, rr_ptr=0. ibuf_pop is combinational and reads 0 while reset is asserted.
- Eligibility: elig[w] = ibuf_valid[w] & ~warp_stall[w].
- Load enable: load = rdy & (~issue_valid | issue_ready) & |elig.
- Grant: first eligible warp scanning rr_ptr, rr_ptr+1, ... mod NUM_WARPS. ibuf_pop = load ? onehot(grant) : 0. The decision is purely combinational in the same cycle, so there is no bubble between buffer and stage.
- On a clock edge with load: issue_inst <= ibuf_inst[grant], issue_warp_id <= grant, issue_valid <= 1, rr_ptr <= (grant+1) mod NUM_WARPS.
- On an edge with rdy & issue_valid & issue_ready & ~load: issue_valid <= 0. Data holds its last value.
- Accept and load in the same cycle: the new instruction replaces the old one and valid stays 1. This gives full throughput of 1 instr/cycle.
- issue_count increments by 1 on every edge with rdy & issue_valid & issue_ready. It wraps 0xFFFFFFFF -> 0.
- Output stability: while issue_valid & ~issue_ready, issue_inst and issue_warp_id must not change. ibuf_pop stays 0.
- rr_ptr advances only on a grant. With no eligible warp it holds.
- Only one warp is eligible: it is granted every cycle regardless of rr_ptr.
- rdy=0: no pop, no state change; the downstream handshake is also ignored, i.e. no count increment and valid is held.
- Reset mid-operation: the held instruction is discarded and not counted. The upstream buffers are not popped during reset.
- warp_stall rising in the same cycle as the buffer becomes valid: the warp is not granted. Stall is sampled combinationally each cycle.

Test Plan:
- NUM_WARPS=4, all ibuf_valid=1, no stall, issue_ready=1 -> grants w0,w1,w2,w3,w0 on consecutive cycles. issue_valid stays 1 from cycle 1, and issue_count=4 after 5 cycles.
- Only warp 2 valid with inst 0xDEAD_BEEF, issue_ready=0 for 3 cycles -> one pop of w2. issue_inst holds 0xDEADBEEF and issue_warp_id holds 2. No further pops until ready=1, then the next pop happens in that same cycle.
- All valid, warp_stall=4'b0101, rr_ptr=0 -> grants alternate w1,w3,w1. w0 and w2 are never popped.
- Back-pressure toggle with issue_ready=1,0,1,0 and all warps valid -> exactly 2 instructions accepted, no duplicates or drops, and issue_count=2.
- rdy=0 for 2 cycles while issue_valid=1 and issue_ready=1 -> ibuf_pop=0, and issue_count and outputs are unchanged.
- Assert rst_n asynchronously mid-stream, between edges -> issue_valid drops to 0 immediately and issue_count=0. After release, the first grant goes to w0.
